// File: rtl/tinyalu_pkg.sv
//------------------------------------------------------------------------------
// Module   : tinyalu_pkg
// Purpose  : Shared types and widths for the memory-port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tinyalu_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin; bit 0 = fetch, bit 1 = data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
    import tinyalu_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_t  last,
    output logic [1:0] grant
);

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == PORT_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Shares one memory interface between fetch and data requesters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import tinyalu_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              cs,
    output logic              read_req,
    output logic              write_req,
    output logic [ADDR_W-1:0] addrout,
    output logic [DATA_W-1:0] datatomem,
    input  logic [DATA_W-1:0] datafrommem,
    input  logic              mem_resp
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_arb_state_t    state_q, state_d;
    arb_port_t         last_q, last_d, port_q, port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d, d_done_q, d_done_d;
    logic              if_err_q, if_err_d, d_err_q, d_err_d;

    logic [1:0]        w_grant;
    logic              w_timeout;
    logic [DATA_W-1:0] w_resp_data;

    rr_arb2 u_rr_arb2 (
        .req   ({d_req, if_req}),
        .last  (last_q),
        .grant (w_grant)
    );

    assign w_timeout   = (cnt_q == CNT_W'(TIMEOUT));
    assign w_resp_data = mem_resp ? datafrommem : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= PORT_D;
            port_q     <= PORT_IF;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_err_q   <= if_err_d;
            d_err_q    <= d_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|w_grant) state_d = BUSY;
            BUSY:    if (mem_resp || w_timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d     = last_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_err_d   = if_err_q;
        d_err_d    = d_err_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|w_grant) begin
                    port_d = w_grant[1] ? PORT_D : PORT_IF;
                    last_d = port_d;
                    cs_d   = 1'b1;
                    wr_d   = w_grant[1] & d_we;
                    rd_d   = ~(w_grant[1] & d_we);
                    addr_d = w_grant[1] ? d_addr : if_addr;
                    wdat_d = (w_grant[1] && d_we) ? d_wdata : '0;
                    // Count includes the first BUSY cycle so the abort lands at TIMEOUT.
                    cnt_d  = CNT_W'(1);
                end
            end
            BUSY: begin
                if (mem_resp || w_timeout) begin
                    cs_d = 1'b0;
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (port_q == PORT_IF) begin
                        if_done_d  = 1'b1;
                        if_err_d   = ~mem_resp;
                        if_rdata_d = w_resp_data;
                    end else begin
                        d_done_d = 1'b1;
                        d_err_d  = ~mem_resp;
                        if (!wr_q) d_rdata_d = w_resp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    assign cs        = cs_q;
    assign read_req  = rd_q;
    assign write_req = wr_q;
    assign addrout   = addr_q;
    assign datatomem = wdat_q;
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized scoreboard bench for mem_port_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 16;
    localparam int TMO = 4;
    localparam int NTX = 60;

    typedef struct {
        int          lat;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic        rd;
        logic        wr;
        logic [DW-1:0] wdata;
    } mem_item_t;

    typedef struct {
        int          port;
        int          cyc;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          if_done, if_err, d_done, d_err;
    logic          cs, read_req, write_req, mem_resp;
    logic [AW-1:0] addrout;
    logic [DW-1:0] datatomem, datafrommem;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mem_item_t mem_q[$];
    exp_item_t exp_q[$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .cs(cs), .read_req(read_req), .write_req(write_req),
        .addrout(addrout), .datatomem(datatomem),
        .datafrommem(datafrommem), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester-side model state
    bit            if_pend = 0, d_pend = 0;
    logic [AW-1:0] ifa = '0, da = '0;
    logic          dwe = 1'b0;
    logic [DW-1:0] dwd = '0;
    int            last_port = 1;
    logic [DW-1:0] m_if_rdata = '0, m_d_rdata = '0;

    task automatic new_fetch();
        if_pend = 1; ifa = AW'($urandom);
    endtask

    task automatic new_data();
        d_pend = 1; da = AW'($urandom); dwe = 1'($urandom_range(0, 1)); dwd = DW'($urandom);
    endtask

    task automatic drive();
        if_req = if_pend; if_addr = ifa;
        d_req = d_pend; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    // Issue one transaction for a given winner; returns cycles until done is visible.
    task automatic issue(input int win, input int lat, input logic [DW-1:0] data, output int wait_n);
        mem_item_t m;
        exp_item_t e;
        bit is_wr;
        int k;
        is_wr   = (win == 1) && dwe;
        m.lat   = lat;
        m.data  = data;
        m.addr  = (win == 1) ? da : ifa;
        m.rd    = !is_wr;
        m.wr    = is_wr;
        m.wdata = is_wr ? dwd : '0;
        mem_q.push_back(m);
        k = (lat > TMO) ? TMO : lat;
        e.port = win;
        e.cyc  = cyc + 1 + k;
        e.err  = (lat > TMO);
        if (win == 0) begin
            m_if_rdata = (lat > TMO) ? '0 : data;
            e.rdata    = m_if_rdata;
        end else begin
            if (!is_wr) m_d_rdata = (lat > TMO) ? '0 : data;
            e.rdata = m_d_rdata;
        end
        exp_q.push_back(e);
        wait_n = 1 + k;
    endtask

    // Stimulus
    initial begin
        int win, lat, wn;
        logic [DW-1:0] data;
        reset = 1'b1;
        if_pend = 0; d_pend = 0;
        drive();
        @(negedge clk);
        check("rst_cs", cs, 0);
        check("rst_read_req", read_req, 0);
        check("rst_write_req", write_req, 0);
        check("rst_addrout", addrout, 0);
        check("rst_datatomem", datatomem, 0);
        check("rst_if_done", if_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < NTX || if_pend || d_pend; t++) begin
            if (t < NTX) begin
                if (t == 0) begin
                    if_pend = 1; ifa = 14'h0123;
                end else if (t == 1) begin
                    d_pend = 1; da = 14'h3FFF; dwe = 1'b1; dwd = 16'hA5A5;
                end else if (t < 6) begin
                    if (!if_pend) new_fetch();
                    if (!d_pend) new_data();
                end else begin
                    if (!if_pend && !d_pend && $urandom_range(0, 2) == 0)
                        repeat ($urandom_range(1, 3)) @(negedge clk);
                    if (!if_pend && $urandom_range(0, 1) == 1) new_fetch();
                    if (!d_pend && $urandom_range(0, 1) == 1) new_data();
                    if (!if_pend && !d_pend) begin
                        if ($urandom_range(0, 1) == 1) new_fetch(); else new_data();
                    end
                end
            end
            drive();
            if (if_pend && d_pend) win = (last_port == 1) ? 0 : 1;
            else                   win = if_pend ? 0 : 1;
            last_port = win;
            if (t == 0)      begin lat = 2; data = 16'hBEEF; end
            else if (t < 6)  begin lat = 1; data = DW'($urandom); end
            else begin
                lat  = (win == 1 && dwe) ? $urandom_range(1, TMO) : $urandom_range(1, TMO + 2);
                data = DW'($urandom);
            end
            issue(win, lat, data, wn);
            repeat (wn) @(negedge clk);
            if (win == 0) begin
                if ((t >= 2 && t < 5) || (t >= 6 && t < NTX && $urandom_range(0, 1) == 1)) new_fetch();
                else if_pend = 0;
            end else begin
                if ((t >= 2 && t < 5) || (t >= 6 && t < NTX && $urandom_range(0, 1) == 1)) new_data();
                else d_pend = 0;
            end
            drive();
            @(negedge clk);
        end

        // Reset during BUSY: abandoned data read, fetch waiting behind it.
        d_pend = 1; dwe = 1'b0; da = 14'h0AAA;
        drive();
        mem_q.push_back('{lat: 1000, data: '0, addr: da, rd: 1'b1, wr: 1'b0, wdata: '0});
        @(negedge clk);
        @(negedge clk);
        if_pend = 1; ifa = 14'h0555;
        drive();
        #2;
        check("busy_cs_before_reset", cs, 1);
        reset = 1'b1;
        #1;
        check("async_rst_cs", cs, 0);
        check("async_rst_read_req", read_req, 0);
        check("async_rst_write_req", write_req, 0);
        check("async_rst_addrout", addrout, 0);
        check("async_rst_rdata", {if_rdata, d_rdata}, 0);
        m_if_rdata = '0; m_d_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_port = 0;
        issue(0, 2, DW'($urandom), wn);
        repeat (wn) @(negedge clk);
        if_pend = 0;
        drive();
        @(negedge clk);
        last_port = 1;
        issue(1, 1, DW'($urandom), wn);
        repeat (wn) @(negedge clk);
        d_pend = 0;
        drive();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Memory model: responds after the latency chosen at issue time.
    initial begin
        mem_item_t cur;
        bit active = 0;
        int cnt = 0;
        mem_resp = 1'b0;
        datafrommem = '0;
        cur = '{lat: 1000, data: '0, addr: '0, rd: 1'b0, wr: 1'b0, wdata: '0};
        forever begin
            @(negedge clk);
            mem_resp = 1'b0;
            datafrommem = DW'($urandom);
            if (reset) begin
                active = 0;
            end else if (cs) begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (mem_q.size() == 0) begin
                        check("unexpected_cs", 1, 0);
                        cur.lat = 1000;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                cnt++;
                check("mem_read_req", read_req, cur.rd);
                check("mem_write_req", write_req, cur.wr);
                check("mem_addrout", addrout, cur.addr);
                check("mem_datatomem", datatomem, cur.wdata);
                if (cnt == cur.lat) begin
                    mem_resp = 1'b1;
                    datafrommem = cur.data;
                end
            end else begin
                active = 0;
                // Stray responses outside BUSY must be ignored.
                if ($urandom_range(0, 4) == 0) mem_resp = 1'b1;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_item_t e;
        if (!reset) begin
            if (if_done || d_done) begin
                check("single_done", {if_done, d_done} == 2'b11, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_port", d_done ? 1 : 0, e.port);
                    check("done_cycle", cyc, e.cyc);
                    check("done_rdata", d_done ? d_rdata : if_rdata, e.rdata);
                    check("done_err", d_done ? d_err : if_err, e.err);
                    check("done_strobes_low", {cs, read_req, write_req}, 0);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("done_missing", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
